// File: rtl/micro_pkg_v.sv
// Shared widths, opcodes, micro-code values and sequencer state encoding.
// Imported by the sequencer, its ROM and the micro decoder.
package micro_pkg_v;

  localparam int CODE_W  = 4;
  localparam int OPC_W   = 2;
  localparam int MAX_LEN = 4;
  localparam int STEP_W  = $clog2(MAX_LEN);

  localparam logic [OPC_W-1:0] OP_NOP   = 2'b00;
  localparam logic [OPC_W-1:0] OP_LOAD  = 2'b01;
  localparam logic [OPC_W-1:0] OP_ADD   = 2'b10;
  localparam logic [OPC_W-1:0] OP_STORE = 2'b11;

  localparam logic [CODE_W-1:0] MC_NOP  = 4'b0000;
  localparam logic [CODE_W-1:0] MC_RD   = 4'b0001;
  localparam logic [CODE_W-1:0] MC_WB   = 4'b0010;
  localparam logic [CODE_W-1:0] MC_FIN  = 4'b0011;
  localparam logic [CODE_W-1:0] MC_ALU  = 4'b0100;
  localparam logic [CODE_W-1:0] MC_AGEN = 4'b1000;
  localparam logic [CODE_W-1:0] MC_MEMW = 4'b1001;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/micro_rom_v.sv
// Microprogram ROM: (opcode, step) -> micro-code plus last-step flag.
// Sequence lengths are defined only here.
module micro_rom_v
  import micro_pkg_v::*;
(
  input  logic [OPC_W-1:0]  i_op,
  input  logic [STEP_W-1:0] i_step,
  output logic [CODE_W-1:0] o_code,
  output logic              o_last
);

  logic [STEP_W-1:0] last_step;

  always_comb begin
    o_code    = MC_NOP;
    last_step = '0;
    unique case (i_op)
      OP_NOP: begin
        last_step = 2'd0;
        o_code    = MC_NOP;
      end
      OP_LOAD: begin
        last_step = 2'd1;
        o_code    = i_step[0] ? MC_WB : MC_RD;
      end
      OP_ADD: begin
        last_step = 2'd2;
        unique case (1'b1)
          (i_step == 2'd0): o_code = MC_RD;
          (i_step == 2'd1): o_code = MC_ALU;
          default:          o_code = MC_WB;
        endcase
      end
      OP_STORE: begin
        last_step = 2'd3;
        unique case (i_step)
          2'd0:    o_code = MC_RD;
          2'd1:    o_code = MC_AGEN;
          2'd2:    o_code = MC_MEMW;
          default: o_code = MC_FIN;
        endcase
      end
    endcase
  end

  assign o_last = (i_step == last_step);

endmodule

// File: rtl/micro_seq_v.sv
// Micro-op sequencer: expands an accepted opcode into 1-4 micro-codes,
// one per unstalled cycle, with back-to-back acceptance on the last code.
module micro_seq_v
  import micro_pkg_v::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [OPC_W-1:0]  i_opc,
  output logic              o_ready,
  input  logic              i_stall,
  output logic              o_en,
  output logic [CODE_W-1:0] o_code,
  output logic              o_busy,
  output logic              o_done
);

  state_e            state_q, state_d;
  logic [OPC_W-1:0]  op_q, op_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] rom_code;
  logic              rom_last;
  logic              issue;
  logic              accept;

  micro_rom_v u_rom (
    .i_op   (op_q),
    .i_step (step_q),
    .o_code (rom_code),
    .o_last (rom_last)
  );

  assign issue   = (state_q == S_ISSUE) & !i_stall;
  assign o_ready = !i_rst & ((state_q == S_IDLE) | (issue & rom_last));
  assign accept  = i_valid & o_ready;

  assign o_en   = issue;
  assign o_done = issue & rom_last;
  assign o_busy = (state_q == S_ISSUE);
  // Outside ISSUE the last issued code is held for the consumer.
  assign o_code = (state_q == S_ISSUE) ? rom_code : code_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    step_d  = step_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = i_opc;
          step_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i_stall) begin
          code_d = rom_code;
          if (!rom_last) begin
            step_d = step_q + 1'b1;
          end else if (accept) begin
            op_d   = i_opc;
            step_d = '0;
          end else begin
            state_d = S_IDLE;
            step_d  = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      step_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_micro_seq_v.sv
// Self-checking bench for micro_seq_v: scenario tasks plus a
// scoreboard of expected micro-codes consumed on every o_en strobe.
module tb_micro_seq_v;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [1:0] i_opc = 2'b00;
  logic       i_stall = 1'b0;
  logic       o_ready;
  logic       o_en;
  logic [3:0] o_code;
  logic       o_busy;
  logic       o_done;

  micro_seq_v dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_opc   (i_opc),
    .o_ready (o_ready),
    .i_stall (i_stall),
    .o_en    (o_en),
    .o_code  (o_code),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0] code;
    logic       last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;
  bit   rnd_on = 1'b0;

  function automatic int model_len(input logic [1:0] op);
    return int'(op) + 1;
  endfunction

  function automatic logic [3:0] model_code(input logic [1:0] op,
                                            input int s);
    case (op)
      2'b00: return 4'b0000;
      2'b01: return (s == 0) ? 4'b0001 : 4'b0010;
      2'b10: begin
        if (s == 0) return 4'b0001;
        if (s == 1) return 4'b0100;
        return 4'b0010;
      end
      default: begin
        if (s == 0) return 4'b0001;
        if (s == 1) return 4'b1000;
        if (s == 2) return 4'b1001;
        return 4'b0011;
      end
    endcase
  endfunction

  task automatic push_op(input logic [1:0] op);
    exp_t e;
    for (int s = 0; s < model_len(op); s++) begin
      e.code = model_code(op, s);
      e.last = (s == model_len(op) - 1);
      sb.push_back(e);
    end
  endtask

  always @(negedge i_clk) begin
    if (mon_on) begin
      n_tests++;
      if (o_en === 1'b1) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected code=%b done=%b, none expected",
                   o_code, o_done);
        end else begin
          mon_e = sb.pop_front();
          if (o_code !== mon_e.code || o_done !== mon_e.last) begin
            n_fail++;
            $display("FAIL sb_code got code=%b done=%b exp code=%b done=%b",
                     o_code, o_done, mon_e.code, mon_e.last);
          end
        end
      end else if (o_done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_without_en got done=%b en=%b exp done=0",
                 o_done, o_en);
      end
    end
  end

  task automatic send(input logic [1:0] op, output bit ok);
    ok = 1'b0;
    i_valid = 1'b1;
    i_opc = op;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) push_op(op);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout op=%b ready=%b exp ready=1", op, o_ready);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (sb.size() == 0 && o_busy === 1'b0) break;
    end
    n_tests++;
    if (sb.size() != 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain left=%0d busy=%b exp left=0 busy=0",
               sb.size(), o_busy);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_valid = 1'b1;
    i_opc = 2'b11;
    repeat (3) begin
      @(negedge i_clk);
      n_tests++;
      if ({o_ready, o_en, o_busy, o_done, o_code} !== 8'b0) begin
        n_fail++;
        $display("FAIL rst_outputs got rdy=%b en=%b busy=%b done=%b code=%b exp all 0",
                 o_ready, o_en, o_busy, o_done, o_code);
      end
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    n_tests++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release got busy=%b rdy=%b exp busy=0 rdy=1",
               o_busy, o_ready);
    end
    @(posedge i_clk);
    #1;
    mon_on = 1'b1;
  endtask

  task automatic test_single_store();
    bit ok;
    logic [2:0] expv;
    send(2'b11, ok);
    for (int c = 1; c <= 5; c++) begin
      @(negedge i_clk);
      expv = (c <= 4) ? {2'b11, (c == 4)} : 3'b000;
      n_tests++;
      if ({o_en, o_busy, o_done} !== expv) begin
        n_fail++;
        $display("FAIL store_cycle%0d got en/busy/done=%b exp=%b",
                 c, {o_en, o_busy, o_done}, expv);
      end
    end
    drain();
  endtask

  task automatic test_stall_add();
    bit ok;
    int en_cnt;
    en_cnt = 0;
    send(2'b10, ok);
    @(negedge i_clk);
    en_cnt += int'(o_en);
    @(posedge i_clk);
    #1;
    i_stall = 1'b1;
    repeat (2) begin
      @(negedge i_clk);
      en_cnt += int'(o_en);
      n_tests++;
      if ({o_en, o_done, o_busy, o_code} !== 7'b0010100) begin
        n_fail++;
        $display("FAIL stall_hold got en=%b done=%b busy=%b code=%b exp 0 0 1 0100",
                 o_en, o_done, o_busy, o_code);
      end
    end
    @(posedge i_clk);
    #1;
    i_stall = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      en_cnt += int'(o_en);
    end
    n_tests++;
    if (en_cnt != 3) begin
      n_fail++;
      $display("FAIL stall_en_count got=%0d exp=3", en_cnt);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int en_cnt;
    int done_cnt;
    en_cnt = 0;
    done_cnt = 0;
    send(2'b01, ok);
    i_valid = 1'b1;
    i_opc = 2'b00;
    @(negedge i_clk);
    en_cnt += int'(o_en);
    done_cnt += int'(o_done);
    @(negedge i_clk);
    en_cnt += int'(o_en);
    done_cnt += int'(o_done);
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready got=%b exp=1", o_ready);
    end else begin
      push_op(2'b00);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    en_cnt += int'(o_en);
    done_cnt += int'(o_done);
    n_tests++;
    if (en_cnt != 3 || done_cnt != 2) begin
      n_fail++;
      $display("FAIL b2b_counts got en=%0d done=%0d exp en=3 done=2",
               en_cnt, done_cnt);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bit ok;
    send(2'b11, ok);
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    n_tests++;
    if ({o_en, o_busy, o_done, o_ready} !== 4'b0) begin
      n_fail++;
      $display("FAIL midrst got en=%b busy=%b done=%b rdy=%b exp all 0",
               o_en, o_busy, o_done, o_ready);
    end
    sb.delete();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    send(2'b01, ok);
    @(negedge i_clk);
    n_tests++;
    if (o_en !== 1'b1 || o_code !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_restart got en=%b code=%b exp en=1 code=0001",
               o_en, o_code);
    end
    drain();
  endtask

  task automatic test_ignore_busy();
    bit ok;
    send(2'b10, ok);
    i_valid = 1'b1;
    i_opc = 2'b11;
    @(negedge i_clk);
    n_tests++;
    if (o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_ready got=%b exp=0", o_ready);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    drain();
    repeat (4) @(negedge i_clk);
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_random();
    bit ok;
    logic [1:0] op;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge i_clk);
          #1;
          i_stall = ($urandom_range(0, 3) == 0);
        end
        i_stall = 1'b0;
      end
    join_none
    for (int n = 0; n < 16; n++) begin
      op = 2'($urandom_range(0, 3));
      send(op, ok);
    end
    drain();
    rnd_on = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_stall = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_stall_add();
    test_back_to_back();
    test_reset_mid();
    test_ignore_busy();
    test_random();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/micro_seq_v.md
Name: micro_seq_v

Overview:
- Micro-op sequencer: the issuing end of the micro-code interface (i_en / 4-bit i_code) consumed by the micro decoder.
- Accepts a 2-bit opcode over a valid/ready handshake and expands it into 1-4 consecutive 4-bit micro-codes, one per enabled cycle, from a fixed microprogram ROM.
- Sits between instruction fetch and the micro decoder; its o_en/o_code drive the decoder's i_en/i_code directly.

Parameters:
- CODE_W, 4, micro-code width; must match the decoder's i_code width.
- OPC_W, 2, opcode width; the ROM has 2**OPC_W sequences.
- MAX_LEN, 4, maximum micro-codes per opcode; the step counter is clog2(MAX_LEN) bits.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  opcode offer.
- i_opc  input  OPC_W  opcode; sampled when i_valid & o_ready.
- o_ready  output  1  sequencer can accept an opcode this cycle.
- i_stall  input  1  downstream hold; freezes the sequence.
- o_en  output  1  micro-code valid strobe (to decoder i_en).
- o_code  output  CODE_W  current micro-code (to decoder i_code).
- o_busy  output  1  a sequence is in progress.
- o_done  output  1  one-cycle pulse, coincident with the last code of a sequence.

Behaviour:
- Reset, while i_rst=1 at an edge: state IDLE, step=0, o_en=0, o_code=0, o_done=0, o_busy=0. o_ready is forced 0 while i_rst=1. Reset mid-sequence abandons it; no o_done is produced.
- FSM states: IDLE and ISSUE.
  - IDLE: o_ready=1. On accept (i_valid & o_ready) latch op, step=0, go to ISSUE.
  - ISSUE: stays until the last step is issued without stall.
- Registered outputs. For the cycle after accept and each following ISSUE cycle:
  - o_en=!i_stall
  - o_code=ROM[op][step]
  - o_done=!i_stall & (step==LEN[op]-1)
- Latency: accept at edge k gives the first code valid in cycle k+1.
- Stall: while i_stall=1, o_en=0, o_done=0, and step and o_code hold their values. The code is issued once i_stall drops. No code is skipped or duplicated.
- Step advance: on each edge in ISSUE with i_stall=0, step+1. On the last step, return to IDLE, or start a new op (see back-to-back).
- Back-to-back: o_ready=1 in ISSUE when step==LEN[op]-1 & !i_stall.
  - An accept there loads the new op with step=0.
  - The new sequence's first code follows the old last code with no gap.
- o_busy=1 in ISSUE, including stalled cycles; 0 in IDLE.
- i_opc and i_valid are ignored when o_ready=0. The offer must be held by the source; no buffering.
- ROM, LEN and codes:
  - op 00 NOP, LEN 1: 0000.
  - op 01 LOAD, LEN 2: 0001, 0010.
  - op 10 ADD, LEN 3: 0001, 0100, 0010.
  - op 11 STORE, LEN 4: 0001, 1000, 1001, 0011.
  - ROM entries at step>=LEN are don't-care and never emitted.
- o_code holds its last value when o_en=0. The consumer must qualify by o_en.

Decomposition:
- Shared package micro_pkg_v: CODE_W, OPC_W, MAX_LEN, opcode constants (OP_NOP/OP_LOAD/OP_ADD/OP_STORE), the micro-code constants, and the state encoding (IDLE=0, ISSUE=1). The decoder uses the same package for code values.
- One sub-module: micro_rom_v, a combinational lookup from (op, step) to (code, last flag). LEN lives only in this ROM.
- The FSM, step counter and handshake stay in micro_seq_v.

Test Plan:
- Reset: hold i_rst 3 cycles with i_valid=1 -> o_ready=0, o_en=0, o_code=0, o_busy=0; no accept occurs.
- Single STORE: i_valid=1, i_opc=11 at edge k -> cycles k+1..k+4 o_en=1, o_code=0001, 1000, 1001, 0011; o_done=1 only at k+4; o_busy low at k+5.
- Stall: ADD with i_stall=1 during the 2nd code for 2 cycles -> sequence 0001, (hold 0100 with o_en=0 ×2), 0100, 0010; o_done only with 0010; exactly 3 o_en pulses.
- Back-to-back: LOAD, then NOP offered continuously -> o_en=1 for 3 consecutive cycles: 0001, 0010, 0000; two o_done pulses; o_ready=1 on the 0010 cycle.
- Reset mid-op: assert i_rst during the 2nd STORE code -> next cycle o_en=0, o_busy=0, no o_done. After release a new LOAD starts cleanly at 0001.
- Ignore when busy: during ADD pulse i_valid with i_opc=11 while o_ready=0 -> no effect; only the ADD codes are emitted.
